// File: rtl/sipo_nor_deserializer.sv
// Bit-serial to word-parallel deserializer, LSB first, with a one-entry output register
// and a registered reduce-NOR flag (ZERO) that accompanies each presented word.
module sipo_nor_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             I,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic             SYNC,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             ZERO
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             zero_q, zero_d;
  logic             o_valid_q, o_valid_d;

  logic             at_last;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] word;

  assign at_last  = (cnt_q == LastCnt);
  // SYNC restarts the word at bit 0, so the final-bit stall cannot apply.
  assign I_READY  = SYNC | ~(at_last & o_valid_q & ~O_READY);
  assign accept   = I_VALID & I_READY;
  assign complete = accept & ~SYNC & at_last;
  assign word     = {I, sr_q};

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    o_d       = o_q;
    zero_d    = zero_q;
    o_valid_d = o_valid_q;

    if (SYNC) begin
      if (accept) begin
        sr_d[0] = I;
        cnt_d   = CntW'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (accept) begin
      if (at_last) begin
        o_d       = word;
        zero_d    = ~|word;
        o_valid_d = 1'b1;
        cnt_d     = '0;
      end else begin
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
          if (cnt_q == CntW'(i)) sr_d[i] = I;
        end
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // A completion in the same cycle as a drain replaces the word without a bubble.
    if (o_valid_q && O_READY && !complete) o_valid_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      zero_q    <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      zero_q    <= zero_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign O       = o_q;
  assign ZERO    = zero_q;
  assign O_VALID = o_valid_q;

endmodule

// File: tb/tb_sipo_nor_deserializer.sv
// Scoreboard bench for sipo_nor_deserializer (WIDTH=8): stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_sipo_nor_deserializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         din;
  logic         din_valid;
  logic         din_ready;
  logic         sync;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [W:0] exp_q[$];   // {zero, word}
  int         hs_cyc[$];  // cycle number of each output handshake

  sipo_nor_deserializer #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RESETN (rstn),
    .I      (din),
    .I_VALID(din_valid),
    .I_READY(din_ready),
    .SYNC   (sync),
    .O      (dout),
    .O_VALID(dout_valid),
    .O_READY(dout_ready),
    .ZERO   (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed word is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && dout_valid && dout_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none", dout);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("word", {23'd0, zero, dout}, {23'd0, e});
      end
    end
  end

  task automatic send_bit(input logic b);
    int n = 0;
    din       = b;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) chk("i_ready_timeout", {31'd0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    exp_q.push_back({~|w, w});
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rstn = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_o", {24'd0, dout}, 32'h00);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_iready", {31'd0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Basic word: bits 1,0,1,1,0,0,1,0 -> 0x4D, single-cycle valid pulse.
    send_word(8'h4D);
    @(negedge clk);
    chk("basic_valid_rise", {31'd0, dout_valid}, 32'd1);
    @(negedge clk);
    chk("basic_valid_fall", {31'd0, dout_valid}, 32'd0);
    chk("basic_o_held", {24'd0, dout}, 32'h4D);
    @(posedge clk);
    #1;

    // Reset mid-word discards the 3 partial bits.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_o", {24'd0, dout}, 32'h00);
    chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    send_word(8'h3C);

    // Zero word then 0x80.
    send_word(8'h00);
    send_word(8'h80);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: A=0xFF pending, B=0x01 stalls at its final bit.
    dout_ready = 1'b0;
    send_word(8'hFF);
    exp_q.push_back({1'b0, 8'h01});
    for (int i = 0; i < W - 1; i++) send_bit(i == 0);
    din = 1'b0;
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_iready", {31'd0, din_ready}, 32'd0);
      chk("bp_o_stable", {24'd0, dout}, 32'hFF);
      chk("bp_valid_stable", {31'd0, dout_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    dout_ready = 1'b1;
    @(negedge clk);
    chk("bp_iready_release", {31'd0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid_kept", {31'd0, dout_valid}, 32'd1);
    chk("bp_o_new", {24'd0, dout}, 32'h01);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;

    // Continuous stream: four words, handshakes 8 cycles apart, ZERO 1,0,0,1.
    base = hs_cyc.size();
    send_word(8'h00);
    send_word(8'hFF);
    send_word(8'hA5);
    send_word(8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", hs_cyc.size() - base, 32'd4);
    if (hs_cyc.size() - base == 4) begin
      for (int k = 1; k < 4; k++)
        chk("stream_spacing", hs_cyc[base + k] - hs_cyc[base + k - 1], 32'd8);
    end

    // Resync: 5 bits of 1, SYNC with I=1 becomes bit 0, then 7 zeros -> 0x01.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    exp_q.push_back({1'b0, 8'h01});
    sync = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    chk("sync_iready", {31'd0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    sync = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_nor_deserializer.md
Name: sipo_nor_deserializer

Overview:
- Receiving end of the bit-serial path that feeds our wide reduction logic.
- Accepts one bit per clock on a valid/ready handshake, LSB first, and assembles WIDTH-bit words.
- Presents each completed word on a one-entry output register with valid/ready.
- Alongside each word it emits ZERO, the registered reduce-NOR of that word (1 when every bit is 0).
- Sits between a serial link and the word-parallel consumers that use reduce-NOR results.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  synchronous reset, active-low: sampled on CLK, 0 = reset.
- I  input  1  serial data bit.
- I_VALID  input  1  I holds a valid bit this cycle.
- I_READY  output  1  block accepts I this cycle.
- SYNC  input  1  word-boundary resync; discards any partial word.
- O  output  WIDTH  assembled word; I's first accepted bit lands at O[0].
- O_VALID  output  1  O and ZERO hold an unconsumed word.
- O_READY  input  1  consumer takes the word this cycle.
- ZERO  output  1  ~|O for the word currently presented.

Behaviour:
- Reset, when RESETN=0 at a CLK edge: shift register = 0, bit counter cnt = 0, O = 0, O_VALID = 0, ZERO = 0. Reset wins over every other input, including mid-word and with O_VALID=1; the partial word and the pending word are both lost.
- Accept: a bit is accepted when I_VALID && I_READY.
- I_READY is combinational: 0 only when cnt == WIDTH-1 && O_VALID && !O_READY. Otherwise 1, including during reset cycles, where the bit is ignored.
- Accepted bit with cnt < WIDTH-1: sr[cnt] <= I and cnt <= cnt+1.
- Accepted bit with cnt == WIDTH-1 (word completes):
  - O <= {I, sr[WIDTH-2:0]}.
  - ZERO <= ~|{I, sr[WIDTH-2:0]}.
  - O_VALID <= 1, cnt <= 0.
  - The shift register is not cleared; stale bits are overwritten as the next word fills.
- Latency: O_VALID rises on the edge that accepts the WIDTH-th bit, so it is visible in the cycle after that bit is presented.
- Output drain: O_VALID && O_READY with no completion in the same cycle gives O_VALID <= 0. O and ZERO keep their last values; do not clear them.
- Simultaneous drain and completion in one cycle: the new word replaces the old one and O_VALID stays 1. Back-to-back words therefore sustain one word per WIDTH accepted bits with no bubble.
- Backpressure: with O_VALID=1 and O_READY=0, bits 0..WIDTH-2 of the next word are still accepted. The stall happens only at the final bit (I_READY=0). The final bit is held by the source and accepted in the first cycle O_READY=1.
- O, ZERO and O_VALID are stable while O_VALID=1 and O_READY=0.
- SYNC=1 (not in reset):
  - Discards the partial word.
  - If no bit is accepted that cycle, cnt <= 0.
  - If a bit is accepted that cycle, it is treated as bit 0: sr[0] <= I, cnt <= 1.
  - SYNC never completes a word and never touches O, ZERO or O_VALID.
  - I_READY under SYNC is evaluated as if cnt = 0, i.e. forced 1.
- Consumer rule: ZERO is meaningful only while O_VALID=1.
- All state updates on the rising CLK edge only.

Test Plan:
- Reset mid-word: 3 bits accepted, RESETN=0 for 1 cycle -> O=0x00, O_VALID=0, ZERO=0, cnt=0. The next 8 bits form a fresh word.
- Basic word, WIDTH=8: bits 1,0,1,1,0,0,1,0 with O_READY=1 -> after the 8th edge O=0x4D, ZERO=0, O_VALID high for 1 cycle.
- Zero word: 8 zero bits -> O=0x00, ZERO=1, O_VALID=1. Then bits 0x80 (seven 0s, then 1) -> O=0x80, ZERO=0.
- Backpressure: O_READY=0 with word A (0xFF) pending, stream word B (0x01):
  - bits 0..6 of B are accepted.
  - I_READY=0 at bit 7; O stays 0xFF.
  - O_READY=1 -> A consumed, bit 7 accepted the same cycle, O=0x01, O_VALID stays 1.
- Continuous stream: 4 words (0x00, 0xFF, 0xA5, 0x00) with I_VALID=O_READY=1 for 32 cycles -> 4 single-cycle O_VALID pulses 8 cycles apart. ZERO pattern is 1,0,0,1.
- Resync: 5 bits accepted, then SYNC=1 with I_VALID=1, I=1, then 7 more bits of 0 -> O=0x01, and the 5 earlier bits are absent from O.
